// File: rtl/alu_exec_stage.sv
// ALU execute stage: decodes the ALU control code, computes the ALU result,
// zero flag and branch target, and provides holdable registered copies.
//
// Ports:
//   i_clk, i_nrst            rising-edge clock, synchronous active-low reset
//   i_hold                   1 = registered outputs keep their value
//   i_alu_op, i_func         operation class and R-type function field
//   i_opA, i_opB, i_shift    operands and shift amount
//   i_npc, i_offset          word-address PC+4 and branch offset in words
//   o_alu_ctrl, o_result,
//   o_zf, o_bta              combinational results
//   o_result_q, o_zf_q,
//   o_bta_q                  registered results (1-cycle latency)
module alu_exec_stage (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_hold,
    input  logic [1:0]  i_alu_op,
    input  logic [5:0]  i_func,
    input  logic [31:0] i_opA,
    input  logic [31:0] i_opB,
    input  logic [4:0]  i_shift,
    input  logic [29:0] i_npc,
    input  logic [29:0] i_offset,
    output logic [3:0]  o_alu_ctrl,
    output logic [31:0] o_result,
    output logic        o_zf,
    output logic [29:0] o_bta,
    output logic [31:0] o_result_q,
    output logic        o_zf_q,
    output logic [29:0] o_bta_q
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLTU = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLL  = 4'b1000;
    localparam logic [3:0] C_SRL  = 4'b1001;
    localparam logic [3:0] C_SRA  = 4'b1010;
    localparam logic [3:0] C_NOR  = 4'b1100;

    logic [3:0]  w_func_ctrl;
    logic [3:0]  w_ctrl;
    logic [31:0] w_result;
    logic [31:0] r_result;
    logic        r_zf;
    logic [29:0] r_bta;

    // Unknown function codes fall back to ADD.
    always_comb begin
        w_func_ctrl = C_ADD;
        case (i_func)
            6'b100000, 6'b100001: w_func_ctrl = C_ADD;
            6'b100010, 6'b100011: w_func_ctrl = C_SUB;
            6'b100100:            w_func_ctrl = C_AND;
            6'b100101:            w_func_ctrl = C_OR;
            6'b100110:            w_func_ctrl = C_XOR;
            6'b100111:            w_func_ctrl = C_NOR;
            6'b101010:            w_func_ctrl = C_SLT;
            6'b101011:            w_func_ctrl = C_SLTU;
            6'b000000:            w_func_ctrl = C_SLL;
            6'b000010:            w_func_ctrl = C_SRL;
            6'b000011:            w_func_ctrl = C_SRA;
            default:              w_func_ctrl = C_ADD;
        endcase
    end

    always_comb begin
        w_ctrl = C_ADD;
        unique case (i_alu_op)
            2'b00: w_ctrl = C_ADD;
            2'b01: w_ctrl = C_SUB;
            2'b10: w_ctrl = w_func_ctrl;
            2'b11: w_ctrl = C_OR;
        endcase
    end

    // Shifts operate on opB only; opA is ignored for them.
    always_comb begin
        w_result = 32'd0;
        case (w_ctrl)
            C_AND:  w_result = i_opA & i_opB;
            C_OR:   w_result = i_opA | i_opB;
            C_ADD:  w_result = i_opA + i_opB;
            C_XOR:  w_result = i_opA ^ i_opB;
            C_SLTU: w_result = {31'd0, i_opA < i_opB};
            C_SUB:  w_result = i_opA - i_opB;
            C_SLT:  w_result = {31'd0, $signed(i_opA) < $signed(i_opB)};
            C_SLL:  w_result = i_opB << i_shift;
            C_SRL:  w_result = i_opB >> i_shift;
            C_SRA:  w_result = $unsigned($signed(i_opB) >>> i_shift);
            C_NOR:  w_result = ~(i_opA | i_opB);
            default: w_result = 32'd0;
        endcase
    end

    assign o_alu_ctrl = w_ctrl;
    assign o_result   = w_result;
    assign o_zf       = (w_result == 32'd0);
    assign o_bta      = i_npc + i_offset;

    // Reset wins over hold.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_result <= 32'd0;
            r_zf     <= 1'b0;
            r_bta    <= 30'd0;
        end else if (!i_hold) begin
            r_result <= o_result;
            r_zf     <= o_zf;
            r_bta    <= o_bta;
        end
    end

    assign o_result_q = r_result;
    assign o_zf_q     = r_zf;
    assign o_bta_q    = r_bta;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: randomized and directed stimulus,
// expected values queued by the driver and compared by a separate monitor.
module tb_alu_exec_stage;

    logic        clk;
    logic        nrst;
    logic        hold;
    logic [1:0]  alu_op;
    logic [5:0]  func;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  shamt;
    logic [29:0] npc;
    logic [29:0] offs;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zf;
    logic [29:0] bta;
    logic [31:0] result_q;
    logic        zf_q;
    logic [29:0] bta_q;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        zf;
        logic [29:0] bta;
        logic [31:0] res_q;
        logic        zf_q;
        logic [29:0] bta_q;
    } exp_t;

    exp_t sb[$];
    int   n_issued = 0;

    logic [31:0] m_res_q = 32'd0;
    logic        m_zf_q  = 1'b0;
    logic [29:0] m_bta_q = 30'd0;

    alu_exec_stage dut (
        .i_clk      (clk),
        .i_nrst     (nrst),
        .i_hold     (hold),
        .i_alu_op   (alu_op),
        .i_func     (func),
        .i_opA      (opA),
        .i_opB      (opB),
        .i_shift    (shamt),
        .i_npc      (npc),
        .i_offset   (offs),
        .o_alu_ctrl (alu_ctrl),
        .o_result   (result),
        .o_zf       (zf),
        .o_bta      (bta),
        .o_result_q (result_q),
        .o_zf_q     (zf_q),
        .o_bta_q    (bta_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick the operation from the opcode tables, then evaluate it
    // with plain arithmetic.
    function automatic void ref_alu(
        input  logic [1:0]  op,
        input  logic [5:0]  f,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic [4:0]  sh,
        output logic [3:0]  c,
        output logic [31:0] r
    );
        longint sa;
        longint sb_v;
        logic [31:0] fill;
        if (op == 2'b00)      c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b11) c = 4'b0001;
        else begin
            case (f)
                6'd32, 6'd33: c = 4'b0010;
                6'd34, 6'd35: c = 4'b0110;
                6'd36:        c = 4'b0000;
                6'd37:        c = 4'b0001;
                6'd38:        c = 4'b0011;
                6'd39:        c = 4'b1100;
                6'd42:        c = 4'b0111;
                6'd43:        c = 4'b0101;
                6'd0:         c = 4'b1000;
                6'd2:         c = 4'b1001;
                6'd3:         c = 4'b1010;
                default:      c = 4'b0010;
            endcase
        end
        sa   = a[31] ? longint'(a) - 64'sd4294967296 : longint'(a);
        sb_v = b[31] ? longint'(b) - 64'sd4294967296 : longint'(b);
        fill = b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'b0011: r = a ^ b;
            4'b0101: r = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            4'b0110: r = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4'b0111: r = (sa < sb_v) ? 32'd1 : 32'd0;
            4'b1000: r = 32'(64'(b) * (64'd1 << sh));
            4'b1001: r = 32'(64'(b) / (64'd1 << sh));
            4'b1010: r = (b >> sh) | fill;
            4'b1100: r = ~(a | b);
            default: r = 32'd0;
        endcase
    endfunction

    task automatic apply(
        input logic        n,
        input logic        h,
        input logic [1:0]  op,
        input logic [5:0]  f,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [4:0]  sh,
        input logic [29:0] pc,
        input logic [29:0] of
    );
        exp_t e;
        logic [3:0]  c;
        logic [31:0] r;
        @(negedge clk);
        nrst = n; hold = h; alu_op = op; func = f;
        opA = a; opB = b; shamt = sh; npc = pc; offs = of;
        ref_alu(op, f, a, b, sh, c, r);
        e.id   = n_issued;
        e.ctrl = c;
        e.res  = r;
        e.zf   = (r == 32'd0);
        e.bta  = 30'((64'(pc) + 64'(of)) % 64'h4000_0000);
        if (!n) begin
            m_res_q = 32'd0; m_zf_q = 1'b0; m_bta_q = 30'd0;
        end else if (!h) begin
            m_res_q = e.res; m_zf_q = e.zf; m_bta_q = e.bta;
        end
        e.res_q = m_res_q;
        e.zf_q  = m_zf_q;
        e.bta_q = m_bta_q;
        sb.push_back(e);
        n_issued++;
    endtask

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s item=%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: inputs change on the falling edge, so just after the rising
    // edge both the combinational and registered outputs are settled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("alu_ctrl", e.id, {28'd0, alu_ctrl}, {28'd0, e.ctrl});
                chk("result",   e.id, result, e.res);
                chk("zf",       e.id, {31'd0, zf}, {31'd0, e.zf});
                chk("bta",      e.id, {2'd0, bta}, {2'd0, e.bta});
                chk("result_q", e.id, result_q, e.res_q);
                chk("zf_q",     e.id, {31'd0, zf_q}, {31'd0, e.zf_q});
                chk("bta_q",    e.id, {2'd0, bta_q}, {2'd0, e.bta_q});
            end
        end
    end

    logic [5:0] legal [11] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39,
                               6'd42, 6'd43, 6'd0, 6'd2, 6'd3};

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        int          waited;
        nrst = 1'b0; hold = 1'b0; alu_op = 2'b00; func = 6'd0;
        opA = 32'd0; opB = 32'd0; shamt = 5'd0; npc = 30'd0; offs = 30'd0;

        // reset, with hold high to confirm reset priority
        apply(0, 0, 2'b00, 6'd0, 32'd7, 32'd9, 5'd0, 30'd1, 30'd1);
        apply(0, 1, 2'b01, 6'd0, 32'd3, 32'd3, 5'd0, 30'd2, 30'd2);

        // directed scenarios
        apply(1, 0, 2'b10, 6'b100010, 32'd5, 32'd5, 5'd0, 30'd0, 30'd0);
        apply(1, 0, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0, 30'd4, 30'd4);
        apply(1, 0, 2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0, 30'd4, 30'd4);
        apply(1, 0, 2'b10, 6'b000011, 32'h1234, 32'h8000_0000, 5'd4, 30'd0, 30'd0);
        apply(1, 0, 2'b10, 6'b000010, 32'h1234, 32'h8000_0000, 5'd4, 30'd0, 30'd0);
        apply(1, 0, 2'b10, 6'b000000, 32'h0, 32'h8000_0001, 5'd31, 30'd0, 30'd0);
        apply(1, 0, 2'b00, 6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 30'h3FFF_FFFF, 30'd2);
        apply(1, 0, 2'b11, 6'd0, 32'hF0, 32'h0F, 5'd0, 30'd10, 30'h3FFF_FFFE);
        apply(1, 0, 2'b10, 6'b111111, 32'd40, 32'd2, 5'd0, 30'd0, 30'd0);
        apply(1, 0, 2'b10, 6'b100111, 32'h0, 32'h0, 5'd0, 30'd0, 30'd0);

        // hold, then reset with hold, then resume
        apply(1, 0, 2'b00, 6'd0, 32'h1230, 32'h4, 5'd0, 30'd100, 30'd5);
        apply(1, 1, 2'b01, 6'd0, 32'd9, 32'd9, 5'd0, 30'd7, 30'd7);
        apply(1, 1, 2'b11, 6'd0, 32'hAA, 32'h55, 5'd0, 30'd3, 30'd3);
        apply(0, 1, 2'b00, 6'd0, 32'd1, 32'd2, 5'd0, 30'd1, 30'd1);
        apply(1, 0, 2'b01, 6'd0, 32'd1, 32'd3, 5'd0, 30'd8, 30'd9);

        // randomized
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            if ($urandom_range(0, 9) == 0) b = {1'b1, 31'($urandom)};
            f = ($urandom_range(0, 14) < 11) ? legal[$urandom_range(0, 10)]
                                             : 6'($urandom);
            apply(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) == 0),
                  2'($urandom), f, a, b, 5'($urandom), 30'($urandom),
                  30'($urandom));
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
